// File: rtl/mm_issue_ctrl.sv
// Matrix-multiply issue sequencer: walks (row, col, k), issues MACs, tags results through a token line.
// Optional cycle counter on perf_cycles is built only when MM_ISSUE_CTRL_PERF_EN is defined.
module mm_issue_ctrl #(
    parameter int DIM      = 4,
    parameter int IDX_W    = 2,
    parameter int PIPE_LAT = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             operands_ready,
    output logic             issue,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic [IDX_W-1:0] k,
    output logic             acc_clr,
    output logic             acc_last,
    output logic             result_valid,
    output logic [IDX_W-1:0] result_row,
    output logic [IDX_W-1:0] result_col,
    output logic             busy,
    output logic             done,
    output logic [15:0]      perf_cycles
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DIM - 1);
    localparam logic [IDX_W-1:0]    ONE_IDX   = IDX_W'(1);
    // Every stage except the output stage; a last token there means results are still coming.
    localparam logic [PIPE_LAT-1:0] HEAD_MASK = {PIPE_LAT{1'b1}} >> 1;

    state_t           state_q;
    logic [IDX_W-1:0] row_q, col_q, k_q;
    logic             busy_q, done_q;

    logic [PIPE_LAT-1:0] tok_last_q;
    logic [IDX_W-1:0]    tok_row_q [PIPE_LAT];
    logic [IDX_W-1:0]    tok_col_q [PIPE_LAT];

    logic issue_s, final_s, pending_s;

    assign issue_s   = (state_q == S_ISSUE) && operands_ready;
    assign final_s   = (row_q == LAST_IDX) && (col_q == LAST_IDX) && (k_q == LAST_IDX);
    assign pending_s = |(tok_last_q & HEAD_MASK);

    assign issue    = issue_s;
    assign acc_clr  = issue_s && (k_q == '0);
    assign acc_last = issue_s && (k_q == LAST_IDX);
    assign row      = row_q;
    assign col      = col_q;
    assign k        = k_q;
    assign busy     = busy_q;
    assign done     = done_q;

    assign result_valid = tok_last_q[PIPE_LAT-1];
    assign result_row   = tok_row_q[PIPE_LAT-1];
    assign result_col   = tok_col_q[PIPE_LAT-1];

    // Controller: state, operand indices and the registered busy/done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        row_q   <= '0;
                        col_q   <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_s) begin
                        if (final_s) begin
                            state_q <= S_DRAIN;
                        end else if (k_q != LAST_IDX) begin
                            k_q <= k_q + ONE_IDX;
                        end else if (col_q != LAST_IDX) begin
                            k_q   <= '0;
                            col_q <= col_q + ONE_IDX;
                        end else begin
                            k_q   <= '0;
                            col_q <= '0;
                            row_q <= row_q + ONE_IDX;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!pending_s) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Token line shadowing the MAC pipeline; bubbles carry last=0.
    always_ff @(posedge clk) begin
        if (reset) begin
            tok_last_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                tok_row_q[i] <= '0;
                tok_col_q[i] <= '0;
            end
        end else begin
            tok_last_q[0] <= acc_last;
            tok_row_q[0]  <= row_q;
            tok_col_q[0]  <= col_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tok_last_q[i] <= tok_last_q[i-1];
                tok_row_q[i]  <= tok_row_q[i-1];
                tok_col_q[i]  <= tok_col_q[i-1];
            end
        end
    end

`ifdef MM_ISSUE_CTRL_PERF_EN
    logic [15:0] perf_q, perf_d;

    // Busy-cycle count: cleared by an accepted start, saturating, held while idle.
    always_comb begin
        perf_d = perf_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                perf_d = 16'd0;
            end else begin
                perf_d = perf_q;
            end
        end else if (perf_q != 16'hFFFF) begin
            perf_d = perf_q + 16'd1;
        end else begin
            perf_d = perf_q;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= 16'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 16'd0;
`endif

endmodule

// File: doc/mm_issue_ctrl.md
# mm_issue_ctrl

Sequencer for the matrix-multiply engine. It walks row, column and inner index over a DIM×DIM product and issues one multiply-accumulate per cycle into a fixed-latency MAC pipeline. It tracks in-flight operations with an internal PIPE_LAT-deep token line, so result writeback is tagged with row and column. It raises a single-cycle `done` once the final result has left the pipeline, replacing the free-running counter/shift-register done detection with a proper controller.

## Interface
- `DIM`, 4: matrix dimension; legal range 2..16.
- `IDX_W`, 2: index width; must satisfy 2^IDX_W ≥ DIM.
- `PIPE_LAT`, 11: MAC pipeline latency in cycles, issue to result; legal range 1..32.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a product; sampled only in IDLE.
- `operands_ready`  in  1  operand memories present valid A[row][k] and B[k][col] this cycle.
- `issue`  out  1  MAC consumes operands this cycle.
- `row`, `col`, `k`  out  IDX_W each  current operand indices.
- `acc_clr`  out  1  `issue` with k==0; MAC clears its accumulator.
- `acc_last`  out  1  `issue` with k==DIM-1.
- `result_valid`  out  1  MAC output is a final C element this cycle.
- `result_row`, `result_col`  out  IDX_W each  tag for the result.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `perf_cycles`  out  16  see Configuration.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `start`=1 clears `row`/`col`/`k` to 0 and moves to ISSUE.
  - `start` is ignored in every other state.
- ISSUE:
  - `issue` = `operands_ready`.
  - On each issue, indices advance in k-fastest order: k, then col, then row.
  - The issue with row=col=k=DIM-1 moves to DRAIN; indices hold at DIM-1.
  - `operands_ready`=0 stalls: indices hold and nothing is issued. No timeout.
- DRAIN: waits until the token line holds no `acc_last` token, then moves to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Token line: PIPE_LAT stages of {last, row, col}.
  - Stage 0 loads `acc_last` and the indices on every cycle; non-issue cycles load a bubble.
  - `result_valid` = last bit of the final stage; `result_row` and `result_col` come from the same stage.
  - Only acc_last issues produce results: exactly DIM² results per product, in row-major order.
- Combinational outputs: `acc_clr` = `issue` & (k==0); `acc_last` = `issue` & (k==DIM-1).
- Reset values:
  - state IDLE; indices 0; token line all bubbles.
  - `issue`, `acc_clr`, `acc_last`, `result_valid`, `busy`, `done` all 0; `perf_cycles` 0.
- Reset mid-operation: in-flight tokens are discarded. No `result_valid` or `done` appears afterwards for the aborted product.

## Timing
- `start` sampled high at edge E: ISSUE from cycle E+1, and `busy`=1 from E+1.
- An issue in cycle t produces `result_valid` in cycle t+PIPE_LAT when acc_last=1.
- Stall-free product: issues in cycles 1..DIM³ (relative to E).
  - Last `result_valid` in cycle DIM³+PIPE_LAT.
  - `done` in cycle DIM³+PIPE_LAT+1; `busy` is low from the following cycle.
- Each stall cycle delays all later events by one cycle.
- `start` asserted in the DONE cycle is ignored. The earliest restart is `start` sampled in the first IDLE cycle.

## Configuration
- `MM_ISSUE_CTRL_PERF_EN` defined:
  - `perf_cycles` clears on an accepted `start` and increments every cycle `busy`=1, saturating at 0xFFFF.
  - It holds its value in IDLE until the next `start`.
  - After a stall-free product it reads DIM³+PIPE_LAT+1.
- Not defined: `perf_cycles` is tied to 0 and no counter logic is built.

## Test plan
- DIM=2, PIPE_LAT=11, `operands_ready` held at 1, `start` pulsed:
  - `issue` high cycles 1–8; `acc_clr` in cycles 1,3,5,7.
  - `result_valid` in cycles 13,15,17,19 with (row,col) = (0,0),(0,1),(1,0),(1,1).
  - `done` in cycle 20.
- Same setup with `operands_ready`=0 for cycles 3–5: no issue during the stall; indices hold at (0,1,0); `done` moves to cycle 23.
- `start` re-pulsed while `busy` and in the DONE cycle: no effect; a single `done`; indices unaffected.
- `reset` asserted in cycle 10 of a DIM=2 run: all outputs 0 the next cycle; no `result_valid` or `done` for 40 cycles after.
- DIM=4, PIPE_LAT=1, random `operands_ready` at 50%:
  - exactly 64 issues and 16 row-major results.
  - `done` exactly 2 cycles after the last issue.
- With `MM_ISSUE_CTRL_PERF_EN` defined: `perf_cycles`=20 after the first scenario and 23 after the stall scenario. Without the macro: 0 throughout.
